lcd_cmd_host: RTL and testbench

Command-issuing host for the LCD image controller: fetches a 4-bit command script from a command ROM, presents each command on the controller's cmd/cmd_valid/busy handshake, and, after the terminating Write command, monitors the controller's IRAM write stream, producing a beat count, a 16-bit checksum and an error flag. It sits opposite the controller on the command interface and doubles as the IRAM-side observer in system test and FPGA bring-up.

---
 rtl/lcd_pkg.sv | 39 +++
 rtl/lcd_iram_monitor.sv | 77 +++++++
 rtl/lcd_cmd_host.sv | 155 +++++++++++++++
 tb/tb_lcd_cmd_host.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD command host.
//   - Command codes understood by the LCD image controller.
//   - Script / image sizing constants.
//   - Host FSM state encoding.
//   - cmd_is_invalid(): true for the reserved codes 12-15, which the
//     host skips instead of issuing.
package lcd_pkg;

  localparam int CMD_DEPTH = 64;
  localparam int PIX_NUM   = 64;
  localparam int ADDR_W    = 6;
  localparam int CNT_W     = 7;

  localparam logic [3:0] CMD_WRITE       = 4'd0;
  localparam logic [3:0] CMD_SHIFT_UP    = 4'd1;
  localparam logic [3:0] CMD_SHIFT_DOWN  = 4'd2;
  localparam logic [3:0] CMD_SHIFT_LEFT  = 4'd3;
  localparam logic [3:0] CMD_SHIFT_RIGHT = 4'd4;
  localparam logic [3:0] CMD_MAX         = 4'd5;
  localparam logic [3:0] CMD_MIN         = 4'd6;
  localparam logic [3:0] CMD_AVERAGE     = 4'd7;
  localparam logic [3:0] CMD_ROT_LEFT    = 4'd8;
  localparam logic [3:0] CMD_ROT_RIGHT   = 4'd9;
  localparam logic [3:0] CMD_MIRROR_X    = 4'd10;
  localparam logic [3:0] CMD_MIRROR_Y    = 4'd11;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_FETCH   = 3'd1;
  localparam logic [2:0] ST_LOAD    = 3'd2;
  localparam logic [2:0] ST_READY   = 3'd3;
  localparam logic [2:0] ST_ISSUE   = 3'd4;
  localparam logic [2:0] ST_COLLECT = 3'd5;
  localparam logic [2:0] ST_FINISH  = 3'd6;

  function automatic logic cmd_is_invalid(input logic [3:0] c);
    return (c > CMD_MIRROR_Y);
  endfunction

endpackage

// File: rtl/lcd_iram_monitor.sv
// Observer for the controller's IRAM write stream.
// Accumulates a 16-bit checksum of the written data, counts accepted beats
// and flags out-of-order addresses or a wrong beat total at run end.
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   clr_i           clears all results (run start)
//   en_i            beats and done are only observed while high
//   beat_valid_i    IRAM write strobe
//   beat_addr_i     IRAM write address
//   beat_data_i     IRAM write data
//   done_i          controller run-complete pulse
//   checksum_o      sum of accepted data, mod 2^16
//   beat_cnt_o      accepted beat count
//   err_o           sticky address-order / beat-total error
module lcd_iram_monitor
  import lcd_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clr_i,
  input  logic              en_i,
  input  logic              beat_valid_i,
  input  logic [ADDR_W-1:0] beat_addr_i,
  input  logic [7:0]        beat_data_i,
  input  logic              done_i,
  output logic [15:0]       checksum_o,
  output logic [CNT_W-1:0]  beat_cnt_o,
  output logic              err_o
);

  logic [15:0]      checksum_q, checksum_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic             err_q, err_d;
  logic             beat;

  assign beat = en_i & beat_valid_i;

  always_comb begin
    checksum_d = checksum_q;
    beat_cnt_d = beat_cnt_q;
    err_d      = err_q;
    if (clr_i) begin
      checksum_d = '0;
      beat_cnt_d = '0;
      err_d      = 1'b0;
    end else begin
      if (beat) begin
        checksum_d = checksum_q + {8'h00, beat_data_i};
        beat_cnt_d = beat_cnt_q + CNT_W'(1);
        if (beat_addr_i != beat_cnt_q[ADDR_W-1:0]) begin
          err_d = 1'b1;
        end
      end
      // The total is judged after including a beat that coincides with done.
      if (en_i && done_i && (beat_cnt_d != CNT_W'(PIX_NUM))) begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      checksum_q <= '0;
      beat_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      checksum_q <= checksum_d;
      beat_cnt_q <= beat_cnt_d;
      err_q      <= err_d;
    end
  end

  assign checksum_o = checksum_q;
  assign beat_cnt_o = beat_cnt_q;
  assign err_o      = err_q;

endmodule

// File: rtl/lcd_cmd_host.sv
// Command-issuing host for the LCD image controller.
// Walks a 4-bit command script in the command ROM, hands each command to
// the controller over cmd/cmd_valid/busy, and after the Write command
// observes the IRAM write stream through lcd_iram_monitor.
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   start                run start pulse (accepted in IDLE / FINISH)
//   CROM_rd, CROM_A      command ROM read strobe and address
//   CROM_Q               command word, valid the cycle after CROM_rd
//   cmd, cmd_valid       command and one-cycle strobe to the controller
//   busy                 controller busy, sampled only in READY
//   IRAM_valid/A/D       controller IRAM write stream
//   done                 controller run-complete pulse
//   run_done             high while the run is finished
//   checksum, beat_cnt   IRAM stream results
//   err                  sticky error (invalid cmd, overrun, stream error)
//
// state   | meaning
// IDLE    | waiting for start after reset
// FETCH   | ROM read strobe for current script address
// LOAD    | capture ROM data into cmd_r
// READY   | wait for busy low, then issue or skip cmd_r
// ISSUE   | cmd_valid high for this cycle only
// COLLECT | observing the IRAM stream until done
// FINISH  | run complete, results held
module lcd_cmd_host
  import lcd_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [3:0]        CROM_Q,
  output logic              CROM_rd,
  output logic [ADDR_W-1:0] CROM_A,
  output logic [3:0]        cmd,
  output logic              cmd_valid,
  input  logic              busy,
  input  logic              IRAM_valid,
  input  logic [ADDR_W-1:0] IRAM_A,
  input  logic [7:0]        IRAM_D,
  input  logic              done,
  output logic              run_done,
  output logic [15:0]       checksum,
  output logic [CNT_W-1:0]  beat_cnt,
  output logic              err
);

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        cmd_r_q, cmd_r_d;
  logic [3:0]        cmd_q, cmd_d;
  logic              err_q, err_d;
  logic              start_ok;
  logic              last_addr;
  logic              step;
  logic              mon_err;

  assign start_ok  = start && ((state_q == ST_IDLE) || (state_q == ST_FINISH));
  assign last_addr = (addr_q == ADDR_W'(CMD_DEPTH - 1));

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cmd_r_d = cmd_r_q;
    cmd_d   = cmd_q;
    err_d   = err_q;
    step    = 1'b0;
    if (start_ok) begin
      state_d = ST_FETCH;
      addr_d  = '0;
      err_d   = 1'b0;
    end else begin
      case (state_q)
        ST_FETCH: state_d = ST_LOAD;
        ST_LOAD: begin
          cmd_r_d = CROM_Q;
          state_d = ST_READY;
        end
        ST_READY: begin
          if (!busy) begin
            if (cmd_is_invalid(cmd_r_q)) begin
              err_d = 1'b1;
              step  = 1'b1;
            end else begin
              cmd_d   = cmd_r_q;
              state_d = ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          if (cmd_r_q == CMD_WRITE) begin
            state_d = ST_COLLECT;
          end else begin
            step = 1'b1;
          end
        end
        ST_COLLECT: begin
          if (done) begin
            state_d = ST_FINISH;
          end
        end
        default: ;
      endcase
      // Leaving the last ROM slot without a Write is a script overrun;
      // the address never wraps back to 0.
      if (step) begin
        if (last_addr) begin
          err_d   = 1'b1;
          state_d = ST_FINISH;
        end else begin
          addr_d  = addr_q + ADDR_W'(1);
          state_d = ST_FETCH;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      cmd_r_q <= '0;
      cmd_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cmd_r_q <= cmd_r_d;
      cmd_q   <= cmd_d;
      err_q   <= err_d;
    end
  end

  lcd_iram_monitor u_mon (
    .clk          (clk),
    .reset        (reset),
    .clr_i        (start_ok),
    .en_i         (state_q == ST_COLLECT),
    .beat_valid_i (IRAM_valid),
    .beat_addr_i  (IRAM_A),
    .beat_data_i  (IRAM_D),
    .done_i       (done),
    .checksum_o   (checksum),
    .beat_cnt_o   (beat_cnt),
    .err_o        (mon_err)
  );

  assign CROM_rd   = (state_q == ST_FETCH);
  assign CROM_A    = addr_q;
  assign cmd       = cmd_q;
  assign cmd_valid = (state_q == ST_ISSUE);
  assign run_done  = (state_q == ST_FINISH);
  assign err       = err_q | mon_err;

endmodule

// File: tb/tb_lcd_cmd_host.sv
module tb_lcd_cmd_host;
  import lcd_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  CROM_Q;
  logic        CROM_rd;
  logic [5:0]  CROM_A;
  logic [3:0]  cmd;
  logic        cmd_valid;
  logic        busy;
  logic        IRAM_valid;
  logic [5:0]  IRAM_A;
  logic [7:0]  IRAM_D;
  logic        done;
  logic        run_done;
  logic [15:0] checksum;
  logic [6:0]  beat_cnt;
  logic        err;

  always #5 clk = ~clk;

  lcd_cmd_host dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .CROM_Q     (CROM_Q),
    .CROM_rd    (CROM_rd),
    .CROM_A     (CROM_A),
    .cmd        (cmd),
    .cmd_valid  (cmd_valid),
    .busy       (busy),
    .IRAM_valid (IRAM_valid),
    .IRAM_A     (IRAM_A),
    .IRAM_D     (IRAM_D),
    .done       (done),
    .run_done   (run_done),
    .checksum   (checksum),
    .beat_cnt   (beat_cnt),
    .err        (err)
  );

  // Command ROM model: one-cycle read latency.
  logic [3:0] rom [64];
  always @(posedge clk) begin
    if (CROM_rd) CROM_Q <= rom[CROM_A];
  end

  int n_pass = 0;
  int n_total = 0;

  logic [3:0] iss_cmd [$];
  int         iss_cyc [$];
  int         viol;
  int         rd_n;
  int         cyc;
  bit         timed_out;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic load_rom(input logic [3:0] fill);
    for (int i = 0; i < 64; i++) rom[i] = fill;
  endtask

  // Called at a negedge; returns at the negedge of the first FETCH cycle.
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Controller model: records issued commands, holds busy for 4 cycles
  // after cmd 5, and after cmd 0 streams 64 beats with done on the last.
  // rst_beat >= 0 replaces that beat with a one-cycle reset and returns.
  task automatic run_host(input int max_cyc, input bit data_inc, input bit rep5,
                          input int rst_beat);
    int busy_cnt;
    int beat;
    int a;
    bit prev_v;
    bit fin;
    busy_cnt = 0;
    beat = -1;
    prev_v = 1'b0;
    fin = 1'b0;
    iss_cmd.delete();
    iss_cyc.delete();
    viol = 0;
    rd_n = 0;
    timed_out = 1'b0;
    cyc = 1;
    while (!fin) begin
      if (CROM_rd) rd_n++;
      if (cmd_valid) begin
        if (prev_v || busy) viol++;
        iss_cmd.push_back(cmd);
        iss_cyc.push_back(cyc);
        if (cmd == 4'd5) busy_cnt = 4;
      end
      prev_v = cmd_valid;
      if (run_done) fin = 1'b1;
      busy = (busy_cnt > 0);
      if (busy_cnt > 0) busy_cnt--;
      IRAM_valid = 1'b0;
      done = 1'b0;
      if (beat >= 0 && beat < 64 && !fin) begin
        if (beat == rst_beat) begin
          reset = 1'b1;
          fin = 1'b1;
        end else begin
          a = (rep5 && beat > 5) ? beat - 1 : beat;
          IRAM_valid = 1'b1;
          IRAM_A = 6'(a);
          IRAM_D = data_inc ? 8'(beat) : 8'h01;
          done = (beat == 63);
          beat++;
        end
      end
      if (cmd_valid && cmd == 4'd0 && beat < 0) beat = 0;
      if (!fin) begin
        @(negedge clk);
        cyc++;
        if (cyc > max_cyc) begin
          timed_out = 1'b1;
          fin = 1'b1;
        end
      end
    end
  endtask

  initial begin
    int min_gap;
    int gap;
    int extra_rd;
    int vcnt;
    reset = 1'b1;
    start = 1'b0;
    busy = 1'b0;
    IRAM_valid = 1'b0;
    IRAM_A = '0;
    IRAM_D = '0;
    done = 1'b0;
    load_rom(4'd14);
    @(negedge clk);
    @(negedge clk);
    chk("rst_crom_rd", CROM_rd, 0);
    chk("rst_crom_a", CROM_A, 0);
    chk("rst_cmd", cmd, 0);
    chk("rst_cmd_valid", cmd_valid, 0);
    chk("rst_run_done", run_done, 0);
    chk("rst_checksum", checksum, 0);
    chk("rst_beat_cnt", beat_cnt, 0);
    chk("rst_err", err, 0);
    reset = 1'b0;
    @(negedge clk);

    // Script {0}, all-0x01 image.
    load_rom(4'd14);
    rom[0] = 4'd0;
    pulse_start();
    run_host(500, 1'b0, 1'b0, -1);
    chk("t1_timeout", timed_out, 0);
    chk("t1_n_issue", iss_cmd.size(), 1);
    if (iss_cmd.size() > 0) begin
      chk("t1_cmd", iss_cmd[0], 0);
      chk("t1_first_issue_cyc", iss_cyc[0], 4);
    end
    chk("t1_beat_cnt", beat_cnt, 7'd64);
    chk("t1_checksum", checksum, 16'h0040);
    chk("t1_err", err, 0);
    chk("t1_run_done", run_done, 1);

    // Script {4,4,2,5,0} with busy after cmd 5, incrementing data.
    load_rom(4'd14);
    rom[0] = 4'd4; rom[1] = 4'd4; rom[2] = 4'd2; rom[3] = 4'd5; rom[4] = 4'd0;
    pulse_start();
    run_host(800, 1'b1, 1'b0, -1);
    chk("t2_timeout", timed_out, 0);
    chk("t2_n_issue", iss_cmd.size(), 5);
    if (iss_cmd.size() == 5) begin
      chk("t2_cmd0", iss_cmd[0], 4);
      chk("t2_cmd1", iss_cmd[1], 4);
      chk("t2_cmd2", iss_cmd[2], 2);
      chk("t2_cmd3", iss_cmd[3], 5);
      chk("t2_cmd4", iss_cmd[4], 0);
      min_gap = 1000;
      for (int i = 1; i < 5; i++) begin
        gap = iss_cyc[i] - iss_cyc[i-1];
        if (gap < min_gap) min_gap = gap;
      end
      chk("t2_min_gap", min_gap, 4);
      chk("t2_busy_gap", iss_cyc[4] - iss_cyc[3], 5);
    end
    chk("t2_viol", viol, 0);
    chk("t2_checksum", checksum, 16'h07E0);
    chk("t2_beat_cnt", beat_cnt, 7'd64);
    chk("t2_err", err, 0);

    // Script {3,13,0}: invalid code skipped.
    load_rom(4'd14);
    rom[0] = 4'd3; rom[1] = 4'd13; rom[2] = 4'd0;
    pulse_start();
    run_host(800, 1'b0, 1'b0, -1);
    chk("t3_timeout", timed_out, 0);
    chk("t3_n_issue", iss_cmd.size(), 2);
    if (iss_cmd.size() == 2) begin
      chk("t3_cmd0", iss_cmd[0], 3);
      chk("t3_cmd1", iss_cmd[1], 0);
    end
    chk("t3_err", err, 1);
    chk("t3_run_done", run_done, 1);
    chk("t3_beat_cnt", beat_cnt, 7'd64);

    // Repeated IRAM address 5.
    load_rom(4'd14);
    rom[0] = 4'd0;
    pulse_start();
    run_host(500, 1'b0, 1'b1, -1);
    chk("t4_timeout", timed_out, 0);
    chk("t4_err", err, 1);
    chk("t4_beat_cnt", beat_cnt, 7'd64);
    chk("t4_checksum", checksum, 16'h0040);

    // 64 non-zero commands: script overrun.
    load_rom(4'd1);
    pulse_start();
    run_host(1000, 1'b0, 1'b0, -1);
    chk("t5_timeout", timed_out, 0);
    chk("t5_n_issue", iss_cmd.size(), 64);
    chk("t5_rd_n", rd_n, 64);
    chk("t5_err", err, 1);
    chk("t5_run_done", run_done, 1);
    chk("t5_crom_a", CROM_A, 63);
    extra_rd = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (CROM_rd) extra_rd++;
    end
    chk("t5_rd_after", extra_rd, 0);

    // Reset during COLLECT, then a clean run.
    load_rom(4'd14);
    rom[0] = 4'd0;
    pulse_start();
    run_host(500, 1'b0, 1'b0, 20);
    chk("t6_timeout", timed_out, 0);
    @(negedge clk);
    chk("t6_crom_rd", CROM_rd, 0);
    chk("t6_crom_a", CROM_A, 0);
    chk("t6_cmd", cmd, 0);
    chk("t6_cmd_valid", cmd_valid, 0);
    chk("t6_run_done", run_done, 0);
    chk("t6_checksum", checksum, 0);
    chk("t6_beat_cnt", beat_cnt, 0);
    chk("t6_err", err, 0);
    reset = 1'b0;
    vcnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (cmd_valid) vcnt++;
    end
    chk("t6_no_valid", vcnt, 0);
    pulse_start();
    run_host(500, 1'b0, 1'b0, -1);
    chk("t6b_timeout", timed_out, 0);
    chk("t6b_err", err, 0);
    chk("t6b_beat_cnt", beat_cnt, 7'd64);
    chk("t6b_checksum", checksum, 16'h0040);
    chk("t6b_run_done", run_done, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
